// File: rtl/fp_pkg.sv
// Shared FP16/FP32 types, constants and exact/RNE format conversions for the dot-product path.
// FP16_DOT_ACC_SAT_EN: finite FP16 overflow saturates to +/-65504 instead of +/-inf.
package fp_pkg;

    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;
    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;

    typedef struct packed {
        logic                  sign;
        logic [FP16_EXP_W-1:0] exp;
        logic [FP16_MAN_W-1:0] man;
    } fp16_t;

    typedef struct packed {
        logic                  sign;
        logic [FP32_EXP_W-1:0] exp;
        logic [FP32_MAN_W-1:0] man;
    } fp32_t;

    localparam logic [15:0] FP16_QNAN     = 16'h7E00;
    localparam logic [15:0] FP16_INF      = 16'h7C00;
    localparam logic [15:0] FP16_MAX      = 16'h7BFF;
    localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] FP32_NEG_ZERO = 32'h8000_0000;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } acc_state_t;

    // Exact widening; FP16 subnormals become normal FP32 values.
    function automatic fp32_t fp16_to_fp32(input fp16_t h);
        fp32_t f;
        int    lead;
        f.sign = h.sign;
        f.exp  = '0;
        f.man  = '0;
        lead   = 0;
        if (h.exp == 5'h1F) begin
            f.exp = 8'hFF;
            f.man = {h.man, 13'b0};
        end else if (h.exp != 5'h00) begin
            f.exp = {3'b0, h.exp} + 8'd112;
            f.man = {h.man, 13'b0};
        end else if (h.man != 10'h000) begin
            for (int i = 0; i < 10; i++) begin
                if (h.man[i]) lead = i;
            end
            f.exp = 8'(lead + 103);
            f.man = 23'({h.man, 13'b0} << (10 - lead));
        end
        return f;
    endfunction

    // RNE on the 13 dropped bits; results below 2^-14 flush to signed zero.
    function automatic fp16_t fp32_to_fp16(input fp32_t f);
        fp16_t       h;
        logic        up;
        logic [10:0] m_rnd;
        int          e;
        h.sign = f.sign;
        h.exp  = '0;
        h.man  = '0;
        up     = f.man[12] & ((|f.man[11:0]) | f.man[13]);
        m_rnd  = {1'b0, f.man[22:13]} + {10'b0, up};
        e      = int'(f.exp) - 112 + int'(m_rnd[10]);
        if (f.exp == 8'hFF) begin
            if (f.man != '0) begin
                h = fp16_t'(FP16_QNAN);
            end else begin
                h.exp = 5'h1F;
            end
        end else if (e < 1) begin
            h.exp = '0;
        end else if (e > 30) begin
`ifdef FP16_DOT_ACC_SAT_EN
            h.exp = 5'h1E;
            h.man = 10'h3FF;
`else
            h.exp = 5'h1F;
            h.man = 10'h000;
`endif
        end else begin
            h.exp = 5'(e);
            h.man = m_rnd[9:0];
        end
        return h;
    endfunction

endpackage

// File: rtl/fp32_add_rne.sv
// Combinational IEEE FP32 adder: align with sticky, add/sub, normalize, RNE, NaN/inf flags.
module fp32_add_rne
    import fp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        nan,
    output logic        inf
);

    fp32_t       fa, fb, hi, lo;
    logic        a_nan, b_nan, a_inf, b_inf, eff_sub, up;
    logic [7:0]  e_hi, e_lo, d;
    logic [26:0] m_hi, m_lo, al, mask, n;
    logic [27:0] s;
    logic [8:0]  e_n, e_f;
    logic [24:0] r;
    int          lz, sh;

    always_comb begin
        fa    = a;
        fb    = b;
        a_nan = (fa.exp == 8'hFF) && (fa.man != '0);
        b_nan = (fb.exp == 8'hFF) && (fb.man != '0);
        a_inf = (fa.exp == 8'hFF) && (fa.man == '0);
        b_inf = (fb.exp == 8'hFF) && (fb.man == '0);

        // Order by magnitude so the subtraction below never goes negative.
        if (a[30:0] >= b[30:0]) begin
            hi = fa;
            lo = fb;
        end else begin
            hi = fb;
            lo = fa;
        end
        e_hi = (hi.exp == 8'h00) ? 8'd1 : hi.exp;
        e_lo = (lo.exp == 8'h00) ? 8'd1 : lo.exp;
        m_hi = {hi.exp != 8'h00, hi.man, 3'b000};
        m_lo = {lo.exp != 8'h00, lo.man, 3'b000};
        d    = e_hi - e_lo;
        mask = '0;
        if (d >= 8'd27) begin
            al = {26'b0, |m_lo};
        end else begin
            mask  = ~(27'h7FF_FFFF << d);
            al    = m_lo >> d;
            al[0] = al[0] | (|(m_lo & mask));
        end

        eff_sub = hi.sign ^ lo.sign;
        s = eff_sub ? ({1'b0, m_hi} - {1'b0, al}) : ({1'b0, m_hi} + {1'b0, al});

        lz = 27;
        for (int i = 0; i < 27; i++) begin
            if (s[i]) lz = 26 - i;
        end
        sh = 0;
        if (s[27]) begin
            n   = {s[27:2], s[1] | s[0]};
            e_n = {1'b0, e_hi} + 9'd1;
        end else begin
            // Never shift below the minimum exponent; the rest stays subnormal.
            sh  = (lz < int'(e_hi) - 1) ? lz : int'(e_hi) - 1;
            n   = s[26:0] << sh;
            e_n = {1'b0, e_hi} - 9'(sh);
        end

        up  = n[2] & (n[1] | n[0] | n[3]);
        r   = {1'b0, n[26:3]} + {24'b0, up};
        e_f = r[24] ? e_n + 9'd1 : e_n;
        if ((r[24] | r[23]) && (e_f >= 9'd255)) begin
            sum = {hi.sign, 8'hFF, 23'b0};
        end else if (r[24]) begin
            sum = {hi.sign, e_f[7:0], 23'b0};
        end else if (r[23]) begin
            sum = {hi.sign, e_f[7:0], r[22:0]};
        end else begin
            sum = {hi.sign, 8'h00, r[22:0]};
        end
        if (s == '0) sum = {fa.sign & fb.sign, 31'b0};

        nan = a_nan | b_nan | (a_inf & b_inf & (fa.sign ^ fb.sign));
        inf = ~nan & (a_inf | b_inf);
        if (nan) begin
            sum = FP32_QNAN;
        end else if (inf) begin
            sum = {a_inf ? fa.sign : fb.sign, 8'hFF, 23'b0};
        end
    end

endmodule

// File: rtl/fp16_dot_acc.sv
// Sums LEN FP16 products in FP32 and emits one RNE-rounded FP16 result per group.
// FP16_DOT_ACC_SAT_EN (see fp_pkg) selects saturation instead of inf on finite overflow.
module fp16_dot_acc
    import fp_pkg::*;
#(
    parameter int LEN = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_fp16,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_fp16
);

    localparam int CNT_W = $clog2(LEN);

    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // sender holds valid and data stable until then, and ready never depends on valid.
    acc_state_t       state, state_next;
    logic [31:0]      acc, add_a, add_b, add_sum;
    logic [CNT_W-1:0] cnt;
    logic             nan_f, add_nan, add_inf, beat, last;
    fp16_t            res16;

    assign beat  = in_valid & in_ready;
    assign last  = (cnt == CNT_W'(LEN - 1));
    // Group starts from -0 so an all -0 group stays -0 while x + -x still gives +0.
    assign add_a = (cnt == '0) ? FP32_NEG_ZERO : acc;
    assign add_b = fp16_to_fp32(in_fp16);

    fp32_add_rne u_add (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum),
        .nan (add_nan),
        .inf (add_inf)
    );

    always_comb begin
        if (nan_f | add_nan) begin
            res16 = fp16_t'(FP16_QNAN);
        end else if (add_inf) begin
            res16 = fp16_t'({add_sum[31], FP16_INF[14:0]});
        end else begin
            res16 = fp32_to_fp16(add_sum);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACC;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ACC: if (beat && last)            state_next = OUT;
            OUT: if (out_valid && out_ready)  state_next = ACC;
            default:                          state_next = ACC;
        endcase
    end

    always_comb begin
        in_ready = (state == ACC) && !rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            nan_f     <= 1'b0;
            out_valid <= 1'b0;
            out_fp16  <= 16'h0000;
        end else begin
            if (beat) begin
                if (last) begin
                    acc       <= '0;
                    cnt       <= '0;
                    nan_f     <= 1'b0;
                    out_valid <= 1'b1;
                    out_fp16  <= res16;
                end else begin
                    acc   <= add_sum;
                    cnt   <= cnt + 1'b1;
                    nan_f <= nan_f | add_nan;
                end
            end
            if (out_valid && out_ready) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp16_dot_acc.sv
// Directed bench for fp16_dot_acc with LEN=8: rounding, specials, backpressure and reset cases.
module tb_fp16_dot_acc;

    localparam int LEN = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_fp16;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_fp16;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    fp16_dot_acc #(.LEN(LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fp16   (in_fp16),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fp16  (out_fp16)
    );

    // Scoreboard: every accepted result is matched against the expected queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected out_fp16=%h expected=none", out_fp16);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (out_fp16 !== e) begin
                    failures++;
                    $display("FAIL sb_result out_fp16=%h expected=%h", out_fp16, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic drive_beat(input logic [15:0] v);
        int budget;
        budget   = 50;
        in_valid = 1'b1;
        in_fp16  = v;
        @(negedge clk);
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL beat_accept in_ready=%b expected=1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_group(input logic [15:0] v [8]);
        for (int i = 0; i < LEN; i++) drive_beat(v[i]);
        in_valid = 1'b0;
    endtask

    // Result must be valid right after the last beat and last exactly one cycle.
    task automatic run_group(input string name, input logic [15:0] v [8], input logic [15:0] e);
        out_ready = 1'b1;
        exp_q.push_back(e);
        send_group(v);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_valid out_valid=%b expected=1", name, out_valid);
        end
        checks++;
        if (out_fp16 !== e) begin
            failures++;
            $display("FAIL %s_data out_fp16=%h expected=%h", name, out_fp16, e);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_pulse out_valid=%b in_ready=%b expected=0,1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_fp16   = 16'h0000;
        out_ready = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_fp16 !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state in_ready=%b out_valid=%b out_fp16=%h expected=0,0,0000",
                     in_ready, out_valid, out_fp16);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release in_ready=%b expected=1", in_ready);
        end
    endtask

    task automatic test_arith();
        run_group("ones", '{8{16'h3C00}}, 16'h4800);
        // 1 + 6 - 1.5 + 0 + 0 - 4 - 12 + 7 = -3.5
        run_group("mixed", '{16'h3C00, 16'h4600, 16'hBE00, 16'h0000,
                             16'h0000, 16'hC400, 16'hCA00, 16'h4700}, 16'hC300);
        run_group("rne_tie_even", '{16'h3C00, 16'h1000, 16'h0000, 16'h0000,
                                    16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h3C00);
        run_group("rne_tie_up", '{16'h3C01, 16'h1000, 16'h0000, 16'h0000,
                                  16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h3C02);
    endtask

    task automatic test_zero_subnormal();
        run_group("neg_zero", '{8{16'h8000}}, 16'h8000);
        run_group("cancel_zero", '{16'h3C00, 16'hBC00, 16'h8000, 16'h8000,
                                   16'h8000, 16'h8000, 16'h8000, 16'h8000}, 16'h0000);
        run_group("subn_to_min", '{16'h0200, 16'h0200, 16'h0000, 16'h0000,
                                   16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h0400);
        run_group("subn_flush", '{8{16'h0001}}, 16'h0000);
    endtask

    task automatic test_specials();
`ifdef FP16_DOT_ACC_SAT_EN
        run_group("overflow", '{8{16'h7BFF}}, 16'h7BFF);
`else
        run_group("overflow", '{8{16'h7BFF}}, 16'h7C00);
`endif
        run_group("inf_minus_inf", '{16'h3C00, 16'h7C00, 16'h3C00, 16'hFC00,
                                     16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00}, 16'h7E00);
        run_group("nan_in", '{16'h3C00, 16'h3C00, 16'h7E01, 16'h3C00,
                              16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00}, 16'h7E00);
        run_group("neg_inf", '{16'hFC00, 16'h7BFF, 16'h7BFF, 16'h7BFF,
                               16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h7BFF}, 16'hFC00);
        run_group("after_special", '{8{16'h3C00}}, 16'h4800);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        exp_q.push_back(16'h4800);
        send_group('{8{16'h3C00}});
        in_valid = 1'b1;
        in_fp16  = 16'h4000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_fp16 !== 16'h4800 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d out_valid=%b out_fp16=%h in_ready=%b expected=1,4800,0",
                         i, out_valid, out_fp16, in_ready);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release out_valid=%b in_ready=%b expected=0,1", out_valid, in_ready);
        end
        // The held 2.0 must be the first beat of the next group: 2 + 7*1 = 9.
        exp_q.push_back(16'h4880);
        drive_beat(16'h4000);
        for (int i = 0; i < LEN - 1; i++) drive_beat(16'h3C00);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_fp16 !== 16'h4880) begin
            failures++;
            $display("FAIL bp_next out_valid=%b out_fp16=%h expected=1,4880", out_valid, out_fp16);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        exp_q.push_back(16'h4C00);
        exp_q.push_back(16'hCC00);
        for (int i = 0; i < LEN; i++) drive_beat(16'h4000);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_gap in_ready=%b out_valid=%b expected=0,1", in_ready, out_valid);
        end
        for (int i = 0; i < LEN; i++) drive_beat(16'hC000);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) drive_beat(16'h4000);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_assert out_valid=%b in_ready=%b expected=0,0", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_hold out_valid=%b expected=0", out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_group("rst_mid_after", '{8{16'h3C00}}, 16'h4800);

        // A result held under backpressure is dropped by reset.
        out_ready = 1'b0;
        send_group('{8{16'h4000}});
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_held_pre out_valid=%b expected=1", out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_fp16 !== 16'h0000) begin
            failures++;
            $display("FAIL rst_held_drop out_valid=%b out_fp16=%h expected=0,0000", out_valid, out_fp16);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_group("rst_held_after", '{8{16'h4000}}, 16'h4C00);
    endtask

    initial begin
        test_reset();
        test_arith();
        test_zero_subnormal();
        test_specials();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_pending remaining=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
